ssm_modexp_ctrl: RTL and testbench
==================================

// Module: ssm_modexp_ctrl
// PURPOSE
//  Initiator-side sequencer for the shift-and-subtract modular multiplier core.
//  Computes R = base^exponent mod modulus by left-to-right square-and-multiply.
//  Issues one modular multiplication at a time over the core's start/ready
//  handshake and captures each product. Sits between the host and the core.
// PARAMETERS
//  WIDTH      8  operand/modulus/result width in bits
//  EXP_WIDTH  8  exponent width in bits; bits are scanned MSB first
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  rst        in   1          synchronous, active-high reset
//  start      in   1          host request; sampled only while ready=1
//  base       in   WIDTH      base; requirement: base < modulus
//  exponent   in   EXP_WIDTH  exponent
//  modulus    in   WIDTH      modulus; requirement: modulus != 0
//  ready      out  1          1 only in IDLE
//  done       out  1          one-cycle pulse when result becomes valid
//  result     out  WIDTH      final R; held until the next accepted start
//  mm_start   out  1          core start; one-cycle pulse per multiplication
//  mm_a       out  WIDTH      core operand A (registered)
//  mm_b       out  WIDTH      core operand B (registered)
//  mm_n       out  WIDTH      core modulus (registered copy of modulus)
//  mm_ready   in   1          core idle/complete flag
//  mm_p       in   WIDTH      core product A*B mod N; valid when mm_ready=1 after an op
// BEHAVIOUR
//  Reset: state=IDLE; ready=1; done=0; mm_start=0; result, mm_a, mm_b, mm_n,
//   R, base/exp regs and bit counter are all 0.
//  States: IDLE, LOAD, SQ_ISS, SQ_WAIT, MU_ISS, MU_WAIT, NEXT, FIN.
//  IDLE: ready=1. start=1 -> LOAD. Latch base, exponent and modulus into
//   internal regs; R <= (modulus==1) ? 0 : 1; bit counter <= EXP_WIDTH-1.
//  LOAD: drive mm_n <= modulus reg; go to SQ_ISS.
//  SQ_ISS: wait here while mm_ready=0; this covers a core still running after
//   a mid-operation reset. When mm_ready=1: mm_a <= R; mm_b <= R;
//   mm_start=1 for exactly this cycle; -> SQ_WAIT.
//  SQ_WAIT: ignore mm_ready in the first cycle, because the core is in its load
//   phase. After that, the first cycle with mm_ready=1 captures R <= mm_p.
//   Then exp[cnt]=1 -> MU_ISS, else -> NEXT.
//  MU_ISS / MU_WAIT: same as SQ_*, but with mm_a <= R and mm_b <= base reg.
//  NEXT: cnt==0 -> FIN; else cnt <= cnt-1 -> SQ_ISS.
//  FIN: result <= R; done=1 for this single cycle; -> IDLE.
//  mm_start is never high for two consecutive cycles. It is never high outside
//   SQ_ISS/MU_ISS.
//  mm_a, mm_b and mm_n stay stable from the ISS cycle until the product is
//   captured.
//  Operation count: EXP_WIDTH squarings plus popcount(exponent) multiplies.
//  Latency, with M = core cycles per multiplication (start pulse to mm_ready):
//   3 + sum over ops of (1 + M) + EXP_WIDTH (NEXT cycles), measured from the
//   start-sampling edge to done.
//  exponent=0: every op is a squaring of 1, so result = 1 (0 if modulus=1).
//  start while busy: ignored, not queued.
//  Input changes after acceptance: no effect, since inputs are latched in IDLE.
//  rst mid-operation: IDLE next cycle, mm_start=0, no done, result cleared.
//  base>=modulus or modulus=0: result undefined, but the FSM must still reach FIN.
// TESTING
//  Run with WIDTH=8, EXP_WIDTH=8 against the real multiplier core.
//  Also run against a model with random M in 1..20.
//  T1: base=3, exp=5, N=7 -> done pulse once, result=5; 8 squarings, 2 multiplies.
//  T2: base=2, exp=0xFF, N=11 -> result=10; exactly 16 mm_start pulses.
//  T3: exp=0, base=4, N=9 -> result=1. N=1, any base=0 -> result=0.
//  T4: pulse start again during run (base=5, exp=3, N=13) -> ignored;
//   result=8; ready stays 0 until after done.
//  T5: assert rst mid-SQ_WAIT -> next cycle ready=1, result=0, no done.
//   A new start with base=3, exp=5, N=7 waits for mm_ready, then gives 5.
//  T6: assertions throughout: mm_start one-cycle only; mm_a/mm_b stable while
//   waiting; done coincides with the result update.

Source files
------------

// File: rtl/ssm_modexp_ctrl.sv
// ---------------------------------------------------------------------------
// ssm_modexp_ctrl
//   Sequencer that computes R = base^exponent mod modulus. It scans the
//   exponent MSB first with left-to-right square-and-multiply. Each step is one
//   modular multiplication on an external shift-and-subtract core, issued over
//   the core's start/ready handshake.
//
// Ports
//   clk       in   single clock, all state on the rising edge
//   rst       in   synchronous active-high reset
//   start     in   host request, sampled only while ready=1
//   base      in   WIDTH      base (expected < modulus)
//   exponent  in   EXP_WIDTH  exponent
//   modulus   in   WIDTH      modulus (expected != 0)
//   ready     out  high only while idle
//   done      out  one-cycle pulse when result is updated
//   result    out  WIDTH      final R, held until the next accepted start
//   mm_start  out  one-cycle start pulse to the multiplier core
//   mm_a      out  WIDTH      core operand A
//   mm_b      out  WIDTH      core operand B
//   mm_n      out  WIDTH      core modulus
//   mm_ready  in   core idle / product valid
//   mm_p      in   WIDTH      core product A*B mod N
// ---------------------------------------------------------------------------
module ssm_modexp_ctrl #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  input  logic                 mm_ready,
  input  logic [WIDTH-1:0]     mm_p
);

  localparam int CW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQ_ISS,
    S_SQ_WAIT,
    S_MU_ISS,
    S_MU_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_base;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [WIDTH-1:0]     r_mod;
  logic [WIDTH-1:0]     r_acc;      // running value R
  logic [CW-1:0]        r_cnt;      // exponent bit currently being processed
  logic                 r_first;    // first cycle of a WAIT state
  logic                 r_ready;
  logic                 r_done;
  logic [WIDTH-1:0]     r_result;
  logic                 r_mm_start;
  logic [WIDTH-1:0]     r_mm_a;
  logic [WIDTH-1:0]     r_mm_b;
  logic [WIDTH-1:0]     r_mm_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_exp      <= '0;
      r_mod      <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_mm_start <= 1'b0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_n     <= '0;
    end else begin
      // Pulses default low; only ISS and FIN raise them for one cycle.
      r_mm_start <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_exp   <= exponent;
            r_mod   <= modulus;
            // x mod 1 is always 0, so seed R accordingly.
            r_acc   <= (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_cnt   <= CW'(EXP_WIDTH - 1);
            r_ready <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mm_n  <= r_mod;
          r_state <= S_SQ_ISS;
        end
        S_SQ_ISS: begin
          // The core may still be finishing an operation started before a reset.
          if (mm_ready) begin
            r_mm_a     <= r_acc;
            r_mm_b     <= r_acc;
            r_mm_start <= 1'b1;
            r_first    <= 1'b1;
            r_state    <= S_SQ_WAIT;
          end
        end
        S_SQ_WAIT: begin
          // mm_ready is stale while the core is still sampling the start pulse.
          if (r_first) begin
            r_first <= 1'b0;
          end else if (mm_ready) begin
            r_acc   <= mm_p;
            r_state <= r_exp[r_cnt] ? S_MU_ISS : S_NEXT;
          end
        end
        S_MU_ISS: begin
          if (mm_ready) begin
            r_mm_a     <= r_acc;
            r_mm_b     <= r_base;
            r_mm_start <= 1'b1;
            r_first    <= 1'b1;
            r_state    <= S_MU_WAIT;
          end
        end
        S_MU_WAIT: begin
          if (r_first) begin
            r_first <= 1'b0;
          end else if (mm_ready) begin
            r_acc   <= mm_p;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_cnt == '0) begin
            r_state <= S_FIN;
          end else begin
            r_cnt   <= r_cnt - CW'(1);
            r_state <= S_SQ_ISS;
          end
        end
        S_FIN: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign result   = r_result;
  assign mm_start = r_mm_start;
  assign mm_a     = r_mm_a;
  assign mm_b     = r_mm_b;
  assign mm_n     = r_mm_n;

endmodule

// File: tb/tb_ssm_modexp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssm_modexp_ctrl
//   Bench for ssm_modexp_ctrl with a behavioural multiplier core whose
//   latency is random in 1..20 cycles per operation. Expected results go into
//   a scoreboard queue when a request is driven; they are popped and compared
//   when done pulses.
// ---------------------------------------------------------------------------
module tb_ssm_modexp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base;
  logic [7:0] exponent;
  logic [7:0] modulus;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic       mm_start;
  logic [7:0] mm_a;
  logic [7:0] mm_b;
  logic [7:0] mm_n;
  logic       mm_ready;
  logic [7:0] mm_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ssm_modexp_ctrl #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .modulus  (modulus),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_n     (mm_n),
    .mm_ready (mm_ready),
    .mm_p     (mm_p)
  );

  // ---------------- behavioural multiplier core ----------------
  // This core is not reset by rst, so it can still be busy when the
  // controller leaves reset.
  int         force_m   = 0;
  int         busy      = 0;
  logic       core_rdy  = 1'b1;
  logic [7:0] core_p    = 8'h00;

  assign mm_ready = core_rdy;
  assign mm_p     = core_p;

  always @(posedge clk) begin
    if (busy != 0) begin
      busy <= busy - 1;
      if (busy == 1) core_rdy <= 1'b1;
    end else if (mm_start) begin
      core_p   <= (mm_n == 8'd0) ? 8'd0 : 8'(({8'd0, mm_a} * {8'd0, mm_b}) % {8'd0, mm_n});
      busy     <= (force_m != 0) ? force_m : int'($urandom_range(1, 20));
      core_rdy <= 1'b0;
    end
  end

  // ---------------- scoreboard and protocol monitor ----------------
  typedef struct {
    logic [7:0] res;
    bit         care;
  } exp_t;

  exp_t q[$];

  int         start_total = 0;
  int         done_total  = 0;
  logic       prev_mm_start = 1'b0;
  logic       prev_rst      = 1'b1;
  logic [7:0] prev_a = 8'd0, prev_b = 8'd0, prev_n = 8'd0, prev_result = 8'd0;
  bit         in_op = 1'b0;

  always @(negedge clk) begin
    if (mm_start) begin
      start_total++;
      checks++;
      if (prev_mm_start) begin
        errors++;
        $display("FAIL mm_start_pulse: high two cycles in a row (actual 11, required 10)");
      end
      in_op = 1'b1;
    end
    if (!prev_rst && !mm_start && (mm_a != prev_a || mm_b != prev_b)) begin
      errors++; checks++;
      $display("FAIL operand_stable: a=%0d b=%0d changed from a=%0d b=%0d without mm_start",
               mm_a, mm_b, prev_a, prev_b);
    end
    if (!prev_rst && in_op && mm_n != prev_n) begin
      errors++; checks++;
      $display("FAIL modulus_stable: mm_n=%0d changed from %0d mid-run", mm_n, prev_n);
    end
    if (!prev_rst && !done && result != prev_result) begin
      errors++; checks++;
      $display("FAIL result_with_done: result=%0d changed from %0d without done", result, prev_result);
    end
    if (done) begin
      done_total++;
      checks++;
      in_op = 1'b0;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: result=%0d, no request outstanding", result);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.care && result !== e.res) begin
          errors++;
          $display("FAIL result: actual=%0d required=%0d", result, e.res);
        end else begin
          $display("txn done: result=%0d required=%0d%s", result, e.res, e.care ? "" : " (don't care)");
        end
      end
    end
    if (rst) in_op = 1'b0;
    prev_mm_start = mm_start;
    prev_rst      = rst;
    prev_a        = mm_a;
    prev_b        = mm_b;
    prev_n        = mm_n;
    prev_result   = result;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, actual, required);
    end
  endtask

  function automatic logic [7:0] pow_ref(input logic [7:0] b, input logic [7:0] e, input logic [7:0] n);
    int r;
    r = 1 % int'(n);
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(n);
    return 8'(r);
  endfunction

  // Drive one request, wait for done and check pulse and issue counts.
  task automatic run_op(input string name, input logic [7:0] b, input logic [7:0] e,
                        input logic [7:0] n, input logic [7:0] res, input bit care,
                        input int exp_starts, input bit poke);
    int   s0, d0, busy_ready;
    bit   got;
    exp_t x;
    s0 = start_total;
    d0 = done_total;
    @(posedge clk); #1;
    base = b; exponent = e; modulus = n; start = 1'b1;
    x.res = res; x.care = care;
    q.push_back(x);
    $display("txn %s: base=%0d exp=0x%02h mod=%0d expect=%0d", name, b, e, n, res);
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    busy_ready = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (ready) busy_ready++;
      if (poke && c == 20) begin
        // Second request plus changed inputs while busy: must be ignored.
        start = 1'b1; base = 8'd1; exponent = 8'hFF; modulus = 8'd200;
      end
      if (poke && c == 21) start = 1'b0;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s timeout: no done within 5000 cycles (required done)", name);
    end
    repeat (3) @(negedge clk);
    chk({name, " ready_while_busy"}, busy_ready, 0);
    chk({name, " done_pulses"}, done_total - d0, 1);
    chk({name, " mm_start_count"}, start_total - s0, exp_starts);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [7:0] b;
    logic [7:0] e;
    logic [7:0] n;
    logic [7:0] res;
    int         starts;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"T1",      8'd3,   8'h05, 8'd7,   8'd5,   10};
    vecs[1] = '{"T2",      8'd2,   8'hFF, 8'd11,  8'd10,  16};
    vecs[2] = '{"T3_exp0", 8'd4,   8'h00, 8'd9,   8'd1,   8};
    vecs[3] = '{"T3_mod1", 8'd0,   8'h5A, 8'd1,   8'd0,   12};
    vecs[4] = '{"msb_only",8'd7,   8'h80, 8'd13,  8'd3,   9};
    vecs[5] = '{"lsb_only",8'd200, 8'h01, 8'd251, 8'd200, 9};
    vecs[6] = '{"zero_pow0",8'd0,  8'h00, 8'd5,   8'd1,   8};
    vecs[7] = '{"minus1",  8'd254, 8'hC3, 8'd255, 8'd254, 12};

    rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready",    int'(ready),    1);
    chk("reset done",     int'(done),     0);
    chk("reset mm_start", int'(mm_start), 0);
    chk("reset result",   int'(result),   0);
    chk("reset mm_a",     int'(mm_a),     0);
    chk("reset mm_b",     int'(mm_b),     0);
    chk("reset mm_n",     int'(mm_n),     0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].b, vecs[i].e, vecs[i].n, vecs[i].res, 1'b1, vecs[i].starts, 1'b0);

    // T4: extra start and input changes while busy.
    run_op("T4", 8'd5, 8'h03, 8'd13, 8'd8, 1'b1, 10, 1'b1);

    // Random operands against the reference model.
    for (int k = 0; k < 6; k++) begin
      logic [7:0] n, b, e;
      n = 8'($urandom_range(2, 255));
      b = 8'($urandom_range(0, int'(n) - 1));
      e = 8'($urandom_range(0, 255));
      run_op("rand", b, e, n, pow_ref(b, e, n), 1'b1, 8 + $countones(e), 1'b0);
    end

    // Undefined-result input must still terminate.
    run_op("mod0", 8'd5, 8'h03, 8'd0, 8'd0, 1'b0, 10, 1'b0);

    // T5: reset while the first squaring is outstanding on a slow core.
    begin
      int   d0, c;
      exp_t x;
      force_m = 20;
      @(posedge clk); #1;
      base = 8'd3; exponent = 8'h05; modulus = 8'd7; start = 1'b1;
      x.res = 8'd5; x.care = 1'b1;
      q.push_back(x);
      $display("txn T5_abort: base=3 exp=0x05 mod=7, reset during SQ_WAIT");
      @(posedge clk); #1;
      start = 1'b0;
      for (c = 0; c < 100; c++) begin
        @(negedge clk);
        if (mm_start) break;
      end
      chk("T5 first_issue_seen", int'(c < 100), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      d0 = done_total;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("T5 ready_after_rst",  int'(ready),    1);
      chk("T5 result_after_rst", int'(result),   0);
      chk("T5 done_after_rst",   int'(done),     0);
      chk("T5 mm_start_after_rst", int'(mm_start), 0);
      repeat (4) @(negedge clk);
      chk("T5 no_done", done_total - d0, 0);
      force_m = 0;
      run_op("T5_restart", 8'd3, 8'h05, 8'd7, 8'd5, 1'b1, 10, 1'b0);
    end

    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
